// File: rtl/switch_allocator.sv
// Per-output wormhole switch allocator for a 5-port mesh router.
// Each output arbitrates round-robin among requesting inputs, locks to the
// winning input until its tail flit passes, and gates every grant on
// downstream credit. Grants are combinational; all state is registered.
module switch_allocator #(
  parameter int unsigned NPORTS    = 5,
  parameter int unsigned BUF_DEPTH = 4,
  parameter int unsigned CW        = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NPORTS-1:0]      req_valid_i,
  input  logic [3*NPORTS-1:0]    req_dest_i,
  input  logic [NPORTS-1:0]      req_tail_i,
  input  logic [NPORTS-1:0]      credit_inc_i,
  output logic [NPORTS-1:0]      grant_o,
  output logic [NPORTS-1:0]      out_valid_o,
  output logic [3*NPORTS-1:0]    out_sel_o,
  output logic [CW*NPORTS-1:0]   credit_cnt_o,
  output logic                   credit_err_o
);

  typedef enum logic {StIdle, StLocked} state_e;

  state_e        state_q  [NPORTS];
  logic [2:0]    owner_q  [NPORTS];
  logic [2:0]    rr_ptr_q [NPORTS];
  logic [CW-1:0] credit_q [NPORTS];
  logic          err_q;

  logic [2:0]        dest    [NPORTS];
  logic [2:0]        winner  [NPORTS];
  logic [NPORTS-1:0] granted;

  // Unpack the per-input destination fields.
  always_comb begin
    for (int i = 0; i < NPORTS; i++) begin
      dest[i] = req_dest_i[3*i +: 3];
    end
  end

  // Per-output arbitration: locked outputs serve only their owner, idle
  // outputs search round-robin from rr_ptr. No credit means no grant.
  always_comb begin
    int idx;
    granted = '0;
    idx     = 0;
    for (int o = 0; o < NPORTS; o++) begin
      winner[o] = 3'd0;
      if (credit_q[o] != '0) begin
        if (state_q[o] == StLocked) begin
          if (req_valid_i[owner_q[o]] && (dest[owner_q[o]] == 3'(o))) begin
            granted[o] = 1'b1;
            winner[o]  = owner_q[o];
          end
        end else begin
          for (int k = 0; k < NPORTS; k++) begin
            idx = int'(rr_ptr_q[o]) + k;
            if (idx >= int'(NPORTS)) idx = idx - int'(NPORTS);
            if (!granted[o] && req_valid_i[idx] && (dest[idx] == 3'(o))) begin
              granted[o] = 1'b1;
              winner[o]  = 3'(idx);
            end
          end
        end
      end
    end
  end

  // Drive crossbar select, output valid and input pops; all silent in reset.
  always_comb begin
    grant_o     = '0;
    out_valid_o = '0;
    out_sel_o   = '0;
    if (!rst) begin
      for (int o = 0; o < NPORTS; o++) begin
        out_valid_o[o] = granted[o];
        if (granted[o]) out_sel_o[3*o +: 3] = winner[o];
        for (int i = 0; i < NPORTS; i++) begin
          if (granted[o] && (winner[o] == 3'(i))) grant_o[i] = 1'b1;
        end
      end
    end
  end

  // Pack credit counters and the sticky error flag.
  always_comb begin
    for (int o = 0; o < NPORTS; o++) begin
      credit_cnt_o[CW*o +: CW] = credit_q[o];
    end
    credit_err_o = err_q;
  end

  // Lock FSM, round-robin pointer and credit counter per output.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int o = 0; o < NPORTS; o++) begin
        state_q[o]  <= StIdle;
        owner_q[o]  <= 3'd0;
        rr_ptr_q[o] <= 3'd0;
        credit_q[o] <= CW'(BUF_DEPTH);
      end
      err_q <= 1'b0;
    end else begin
      for (int o = 0; o < NPORTS; o++) begin
        if (granted[o]) begin
          if (state_q[o] == StIdle) begin
            rr_ptr_q[o] <= (winner[o] == 3'(NPORTS - 1)) ? 3'd0 : winner[o] + 3'd1;
            // A head flit that is also a tail leaves the output free.
            if (!req_tail_i[winner[o]]) begin
              state_q[o] <= StLocked;
              owner_q[o] <= winner[o];
            end
          end else if (req_tail_i[winner[o]]) begin
            state_q[o] <= StIdle;
          end
        end

        if (granted[o] && !credit_inc_i[o]) begin
          credit_q[o] <= credit_q[o] - CW'(1);
        end else if (!granted[o] && credit_inc_i[o]) begin
          if (credit_q[o] == CW'(BUF_DEPTH)) begin
            err_q <= 1'b1;
          end else begin
            credit_q[o] <= credit_q[o] + CW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_switch_allocator.sv
// Self-checking bench for switch_allocator: directed scenarios with literal
// expectations plus randomized traffic, all compared against a behavioural
// model of the allocation rules.
module tb_switch_allocator;

  localparam int NP = 5;
  localparam int BD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  req_valid_i, req_tail_i, credit_inc_i;
  logic [14:0] req_dest_i;
  logic [4:0]  grant_o, out_valid_o;
  logic [14:0] out_sel_o, credit_cnt_o;
  logic        credit_err_o;

  switch_allocator dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid_i),
    .req_dest_i   (req_dest_i),
    .req_tail_i   (req_tail_i),
    .credit_inc_i (credit_inc_i),
    .grant_o      (grant_o),
    .out_valid_o  (out_valid_o),
    .out_sel_o    (out_sel_o),
    .credit_cnt_o (credit_cnt_o),
    .credit_err_o (credit_err_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state.
  int m_locked [NP];
  int m_owner  [NP];
  int m_rr     [NP];
  int m_credit [NP];
  int m_err;
  // Model outputs for the current cycle.
  int ev [NP];
  int es [NP];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [14:0] mkdest(input int d0, input int d1, input int d2,
                                          input int d3, input int d4);
    logic [14:0] r;
    r = {3'(d4), 3'(d3), 3'(d2), 3'(d1), 3'(d0)};
    return r;
  endfunction

  function automatic int dfield(input int i);
    logic [14:0] d;
    d = req_dest_i;
    return int'(d[3*i +: 3]);
  endfunction

  function automatic int cfield(input int o);
    logic [14:0] c;
    c = credit_cnt_o;
    return int'(c[3*o +: 3]);
  endfunction

  task automatic model_reset();
    for (int o = 0; o < NP; o++) begin
      m_locked[o] = 0; m_owner[o] = 0; m_rr[o] = 0; m_credit[o] = BD;
    end
    m_err = 0;
  endtask

  // Drive one cycle of inputs at the falling edge, then compare DUT vs model.
  task automatic drive(input logic [4:0] v, input logic [14:0] d, input logic [4:0] t,
                       input logic [4:0] inc, input logic r);
    logic [4:0]  eg;
    logic [14:0] esel, ecred;
    int i;
    req_valid_i = v; req_dest_i = d; req_tail_i = t; credit_inc_i = inc; rst = r;
    #1;
    eg = '0; esel = '0; ecred = '0;
    for (int o = 0; o < NP; o++) begin
      ev[o] = 0; es[o] = 0;
      if (!r && m_credit[o] > 0) begin
        if (m_locked[o] != 0) begin
          i = m_owner[o];
          if (v[i] && dfield(i) == o) begin ev[o] = 1; es[o] = i; end
        end else begin
          for (int k = 0; k < NP; k++) begin
            i = (m_rr[o] + k) % NP;
            if (ev[o] == 0 && v[i] && dfield(i) == o) begin ev[o] = 1; es[o] = i; end
          end
        end
      end
      if (ev[o] != 0) begin
        eg[es[o]] = 1'b1;
        esel[3*o +: 3] = 3'(es[o]);
      end
      ecred[3*o +: 3] = 3'(m_credit[o]);
    end
    check("grant", grant_o, eg);
    check("out_valid", out_valid_o, {ev[4][0], ev[3][0], ev[2][0], ev[1][0], ev[0][0]});
    check("out_sel", out_sel_o, esel);
    check("credit_cnt", credit_cnt_o, ecred);
    check("credit_err", credit_err_o, m_err[0]);
  endtask

  // Advance one clock and update the model with this cycle's outcome.
  task automatic tick();
    int w;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      for (int o = 0; o < NP; o++) begin
        if (ev[o] != 0) begin
          w = es[o];
          if (m_locked[o] != 0) begin
            if (req_tail_i[w]) m_locked[o] = 0;
          end else begin
            m_rr[o] = (w + 1) % NP;
            if (!req_tail_i[w]) begin m_locked[o] = 1; m_owner[o] = w; end
          end
        end
        m_credit[o] = m_credit[o] + (credit_inc_i[o] ? 1 : 0) - ev[o];
        if (m_credit[o] > BD) begin m_credit[o] = BD; m_err = 1; end
      end
    end
    @(negedge clk);
  endtask

  task automatic step(input logic [4:0] v, input logic [14:0] d, input logic [4:0] t,
                      input logic [4:0] inc);
    drive(v, d, t, inc, 1'b0);
    tick();
  endtask

  logic [4:0]  exp_cont [5];
  logic [14:0] rd;
  logic [4:0]  rv, rt, ri;

  initial begin
    exp_cont[0] = 5'b00001; exp_cont[1] = 5'b00100; exp_cont[2] = 5'b10000;
    exp_cont[3] = 5'b00001; exp_cont[4] = 5'b00000;
    model_reset();
    rst = 1'b1; req_valid_i = '1; req_dest_i = '0; req_tail_i = '0; credit_inc_i = '0;
    @(posedge clk);
    @(negedge clk);

    // Reset held with every input requesting: nothing granted.
    for (int c = 0; c < 2; c++) begin
      drive(5'b11111, mkdest(0, 0, 1, 2, 3), 5'b00000, 5'b00000, 1'b1);
      check("reset_grant", grant_o, 5'b00000);
      tick();
    end
    drive(5'b00000, '0, '0, '0, 1'b0);
    check("reset_credit", credit_cnt_o, {5{3'd4}});
    check("reset_valid", out_valid_o, 5'b00000);
    tick();

    // Contention on L from N, E, L with single-flit packets.
    for (int c = 0; c < 5; c++) begin
      drive(5'b10101, mkdest(4, 0, 4, 0, 4), 5'b11111, 5'b00000, 1'b0);
      check("contention_grant", grant_o, exp_cont[c]);
      tick();
    end
    check("contention_credit_L", 32'(cfield(4)), 32'd0);
    for (int c = 0; c < 4; c++) step(5'b00000, '0, '0, 5'b10000);

    // Wormhole lock: S sends 3 flits to E while W also asks for E.
    for (int c = 0; c < 3; c++) begin
      drive(5'b01010, mkdest(0, 2, 0, 2, 0), (c == 2) ? 5'b01010 : 5'b01000, 5'b00000, 1'b0);
      check("wormhole_sel_E", 32'(out_sel_o[8:6]), 32'd1);
      tick();
    end
    drive(5'b01000, mkdest(0, 2, 0, 2, 0), 5'b01000, 5'b00000, 1'b0);
    check("wormhole_W_after", grant_o, 5'b01000);
    tick();
    for (int c = 0; c < 4; c++) step(5'b00000, '0, '0, 5'b00100);

    // Credit stall on N mid-packet from E, W contending.
    for (int c = 0; c < 4; c++) step(5'b01100, mkdest(0, 0, 0, 0, 0), 5'b00000, 5'b00000);
    drive(5'b01100, mkdest(0, 0, 0, 0, 0), 5'b00000, 5'b00000, 1'b0);
    check("stall_grant", grant_o, 5'b00000);
    tick();
    drive(5'b01100, mkdest(0, 0, 0, 0, 0), 5'b00000, 5'b00001, 1'b0);
    check("stall_inc_cycle", grant_o, 5'b00000);
    tick();
    drive(5'b01100, mkdest(0, 0, 0, 0, 0), 5'b00100, 5'b00000, 1'b0);
    check("stall_resume", grant_o, 5'b00100);
    check("stall_owner", 32'(out_sel_o[2:0]), 32'd2);
    tick();
    for (int c = 0; c < 4; c++) step(5'b00000, '0, '0, 5'b00001);

    // Simultaneous grant and credit return on W, then overflow.
    step(5'b10000, mkdest(0, 0, 0, 0, 3), 5'b10000, 5'b00000);
    step(5'b10000, mkdest(0, 0, 0, 0, 3), 5'b10000, 5'b01000);
    check("simul_credit_W", 32'(cfield(3)), 32'd3);
    step(5'b00000, '0, '0, 5'b01000);
    step(5'b00000, '0, '0, 5'b01000);
    check("overflow_credit_W", 32'(cfield(3)), 32'd4);
    check("overflow_err", 32'(credit_err_o), 32'd1);

    // Illegal destination on L never granted.
    for (int c = 0; c < 3; c++) begin
      drive(5'b10001, mkdest(1, 0, 0, 0, 6), 5'b10001, 5'b00000, 1'b0);
      check("illegal_grant", grant_o, 5'b00001);
      tick();
    end

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 1500; c++) begin
      rv = 5'($urandom);
      for (int i = 0; i < NP; i++) begin
        int dd;
        dd = $urandom_range(0, 5);
        if ($urandom_range(0, 19) == 0) dd = 7;
        rd[3*i +: 3] = 3'(dd);
        rt[i] = ($urandom_range(0, 2) == 0);
        ri[i] = ($urandom_range(0, 3) == 0);
      end
      drive(rv, rd, rt, ri, ($urandom_range(0, 199) == 0));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
